// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result pipeline stage.
// Latency: none (package only).
// Backpressure: none (package only).
package alu_pkg;

    localparam int ALU_W     = 32;
    localparam int ALU_TAG_W = 5;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // One buffered ALU result; flags travel with the entry so they are
    // never recomputed from the stored result.
    typedef struct packed {
        logic [ALU_W-1:0]     result;
        logic [2:0]           op;
        logic [ALU_TAG_W-1:0] tag;
        logic                 zero;
        logic                 neg;
    } alu_entry_t;

    // SLT only ever yields 0 or 1, so its sign bit is meaningless; neg is
    // forced low for it. Unknown opcodes get ordinary flags.
    function automatic alu_entry_t alu_make_entry(
        input logic [ALU_W-1:0]     result,
        input logic [2:0]           op,
        input logic [ALU_TAG_W-1:0] tag
    );
        alu_entry_t e;
        e.result = result;
        e.op     = op;
        e.tag    = tag;
        e.zero   = (result == '0);
        e.neg    = (op == OP_SLT) ? 1'b0 : result[ALU_W-1];
        return e;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer for alu_entry_t (main + skid register).
// Latency: 1 cycle from input transfer to out_valid when empty.
// Backpressure: in_ready is registered, drops only when both entries are full.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream (out_data is the main register).
module alu_skid_buf
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  alu_entry_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output alu_entry_t out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    alu_entry_t main_q, skid_q;
    logic       in_ready_q;
    logic       in_xfer, out_xfer;
    logic       load_main_in, load_main_skid, load_skid;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                case ({in_xfer, out_xfer})
                    2'b10: begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end
                    2'b01: state_d = EMPTY;
                    // Main is consumed this edge, so the new entry replaces it.
                    2'b11: load_main_in = 1'b1;
                    default: ;
                endcase
            end
            TWO: begin
                // in_ready is low here, so only the output side can move.
                if (out_xfer) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
            in_ready_q <= (state_d != TWO);
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage after the ALU: captures result/op/tag, derives zero/neg flags.
// Latency: 1 cycle input-to-output when empty; no combinational in->out path.
// Backpressure: two-entry skid, registered in_ready low only when both are full.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_result/in_op/in_tag;
//        out_valid/out_ready/out_result/out_op/out_tag/out_zero/out_neg.
// Optional ALU_RESULT_STAGE_STATS_EN adds stat_ops (output transfers) and
// stat_stall (cycles with out_valid & !out_ready), both wrapping 32-bit counters.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,      // must equal ALU_W (entry layout is fixed)
    parameter int TAG_W = ALU_TAG_W   // must equal ALU_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_op,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
`ifdef ALU_RESULT_STAGE_STATS_EN
    output logic             out_neg,
    output logic [31:0]      stat_ops,
    output logic [31:0]      stat_stall
`else
    output logic             out_neg
`endif
);

    alu_entry_t in_entry, out_entry;

    // Flags are derived once here, at capture time.
    assign in_entry = alu_make_entry(in_result, in_op, in_tag);

    alu_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign out_result = out_entry.result;
    assign out_op     = out_entry.op;
    assign out_tag    = out_entry.tag;
    assign out_zero   = out_entry.zero;
    assign out_neg    = out_entry.neg;

`ifdef ALU_RESULT_STAGE_STATS_EN
    logic [31:0] stat_ops_q, stat_stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ops_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (out_valid & out_ready) begin
                stat_ops_q <= stat_ops_q + 32'd1;
            end
            if (out_valid & !out_ready) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_ops   = stat_ops_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered pipeline stage directly downstream of the 32-bit ALU.
- Captures the ALU's combinational `out` together with its 3-bit `signal` opcode and a tag.
- Derives zero and negative flags and presents everything to the writeback/branch stage over a valid/ready handshake.
- Holds two entries (main plus skid), so upstream `in_ready` is registered and full throughput is kept under backpressure.

Parameters:
- WIDTH, 32, datapath width; must match the ALU width.
- TAG_W, 5, width of the destination/tag field carried alongside each result.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  upstream holds a valid ALU result
- in_ready  output  1  stage can accept a result this cycle
- in_result  input  WIDTH  ALU `out` bus
- in_op  input  3  ALU `signal` used to produce `in_result`
- in_tag  input  TAG_W  destination tag
- out_valid  output  1  result available downstream
- out_ready  input  1  downstream accepts
- out_result  output  WIDTH  registered result
- out_op  output  3  registered opcode
- out_tag  output  TAG_W  registered tag
- out_zero  output  1  out_result == 0
- out_neg  output  1  out_result[WIDTH-1], forced 0 for SLT (3'b111)

Behaviour:
- Opcodes, fixed:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
  - Other codes pass through unchanged; flags are computed normally for them.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Storage and FSM:
  - Storage is a main register (drives the out_* ports) and a skid register.
  - FSM states EMPTY, ONE, TWO.
  - EMPTY: in transfer -> ONE; data goes to main.
  - ONE, in transfer only -> TWO; data goes to skid.
  - ONE, out transfer only -> EMPTY.
  - ONE, both transfers -> ONE; main is loaded with the new input.
  - TWO: in_ready=0. Out transfer -> ONE; skid moves to main.
  - TWO, no out transfer: holds.
- in_ready is registered: 1 in EMPTY and ONE, 0 in TWO.
- out_valid = (state != EMPTY).
- Latency: one cycle from input transfer to out_valid when EMPTY; no combinational path from in_* to out_*.
- Flags:
  - out_zero and out_neg are computed at capture and stored with the entry, so they are never recomputed from out_result.
  - SLT results are 0 or 1. out_neg=0 for SLT; out_zero=1 when a>=b.
- Output stability: while out_valid & !out_ready, all out_* fields hold stable.
- In-order: results leave in arrival order. No drop, no duplication.
- Reset (rst_n=0 at a clk edge):
  - state=EMPTY, out_valid=0, in_ready=0 for that cycle, then 1 the cycle after rst_n rises.
  - out_result=0, out_op=0, out_tag=0, out_zero=0, out_neg=0.
  - Reset mid-operation discards both entries with no partial output.
- Simultaneous in and out transfer in ONE: output holds the old main data that cycle, the new data appears the next cycle, and occupancy is unchanged.
- in_valid is ignored while in_ready=0 (no capture).

Optional Feature:
- Macro ALU_RESULT_STAGE_STATS_EN.
- When defined, adds outputs:
  - stat_ops (32-bit): increments on every output transfer.
  - stat_stall (32-bit): increments each cycle with out_valid & !out_ready.
- Both counters wrap from 32'hFFFFFFFF to 0, reset to 0, and count independently of each other.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - ALU_W=32.
  - Opcode localparams OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT.
  - A struct/typedef alu_entry_t {result, op, tag, zero, neg}.
- One natural sub-module: alu_skid_buf, a generic two-entry valid/ready skid buffer on alu_entry_t. alu_result_stage contains the flag derivation and instantiates it.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0 and all outputs 0; in_ready=1 on the first cycle after release; nothing is captured during reset.
- Single op: in_result=32'h0000_0000, in_op=110, tag=3, out_ready=1 -> next cycle out_valid=1, out_zero=1, out_neg=0, out_tag=3; the following cycle out_valid=0.
- Negative and SLT:
  - 32'h8000_0001 op 010 -> out_neg=1, out_zero=0.
  - 32'h0000_0001 op 111 -> out_neg=0, out_zero=0.
- Backpressure: out_ready=0 while issuing tags 1,2,3 back-to-back -> in_ready drops after the 2nd capture and tag 3 waits; release out_ready -> tags 1,2,3 appear in order with stable data while stalled.
- Streaming: in_valid=1 and out_ready=1 for 100 cycles with random results -> one output per cycle after 1-cycle latency, no bubbles, order preserved.
- Reset mid-operation: occupancy TWO (tags 7,8) then rst_n=0 for one cycle -> out_valid=0 next cycle, tags 7 and 8 never emitted; with ALU_RESULT_STAGE_STATS_EN defined, stat_ops=0 after reset.
